// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC operand feeder: FSM states,
// operand/accumulator widths and the {b,a} pair packing helpers.
package mac_pkg;
  localparam int OPW   = 4;
  localparam int ACCW  = 8;
  localparam int PAIRW = 2 * OPW;
  localparam int A_LSB = 0;
  localparam int B_LSB = OPW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  function automatic logic [OPW-1:0] pair_a(input logic [PAIRW-1:0] p);
    return p[A_LSB +: OPW];
  endfunction

  function automatic logic [OPW-1:0] pair_b(input logic [PAIRW-1:0] p);
    return p[B_LSB +: OPW];
  endfunction
endpackage

// File: rtl/mac_operand_fifo.sv
// Operand-pair buffer: DEPTH entries, show-ahead head, push/pop/flush.
// Pushes while full and pops while empty are silently ignored.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [PAIRW-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [PAIRW-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PAIRW-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs, then clears the MAC, streams the pairs one per
// cycle and captures the accumulated dot product once the stream drains.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [PAIRW-1:0] i_wr_data,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count,
  input  logic             i_start,
  output logic             o_busy,
  output logic [OPW-1:0]   o_mac_a,
  output logic [OPW-1:0]   o_mac_b,
  output logic             o_mac_clr,
  input  logic [ACCW-1:0]  i_mac_acc,
  output logic [ACCW-1:0]  o_result,
  output logic             o_result_valid
);
  feeder_state_t    r_state;
  feeder_state_t    w_next;
  logic [CNT_W-1:0] r_remain;
  logic [OPW-1:0]   r_mac_a;
  logic [OPW-1:0]   r_mac_b;
  logic             r_mac_clr;
  logic [ACCW-1:0]  r_result;
  logic             r_result_valid;

  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_flush;
  logic [PAIRW-1:0] w_head;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic [CNT_W-1:0] w_n;

  assign w_push    = i_wr_en && (r_state == ST_IDLE);
  assign w_push_ok = w_push && !w_fifo_full;
  // A write in the start cycle lands first, so it is part of the run length.
  assign w_n       = w_fifo_count + CNT_W'(w_push_ok);

  mac_operand_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (i_wr_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full)
  );

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_start && (w_n != '0)) w_next = ST_CLEAR;
      ST_CLEAR: begin
        w_next = ST_STREAM;
        w_pop  = 1'b1;
      end
      ST_STREAM: begin
        if (r_remain == '0) w_next = ST_DRAIN;
        else                w_pop  = 1'b1;
      end
      ST_DRAIN:  w_next = ST_DONE;
      ST_DONE: begin
        w_next  = ST_IDLE;
        w_flush = 1'b1;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each lines up with its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_remain       <= '0;
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_mac_clr      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && (w_next == ST_CLEAR)) r_remain <= w_n;
      else if (w_pop)                                  r_remain <= r_remain - CNT_W'(1);
      r_mac_clr      <= (w_next == ST_CLEAR);
      r_mac_a        <= w_pop ? pair_a(w_head) : '0;
      r_mac_b        <= w_pop ? pair_b(w_head) : '0;
      if (r_state == ST_DRAIN) r_result <= i_mac_acc;
      r_result_valid <= (w_next == ST_DONE);
    end
  end

  assign o_full         = w_fifo_full;
  assign o_count        = w_fifo_count;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_mac_a        = r_mac_a;
  assign o_mac_b        = r_mac_b;
  assign o_mac_clr      = r_mac_clr;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Transmit-side driver for the 4x4 MAC accumulator datapath. It buffers up to DEPTH operand pairs written over a byte port. On `start` it clears the MAC accumulator, streams one {b,a} pair per cycle into the MAC operand inputs, and captures the 8-bit accumulated dot product when the stream has drained. It sits between the host-facing pin logic and the MAC, and owns the MAC's accumulator clear.

## Interface
- DEPTH, 8: operand-pair buffer entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  push `wr_data` into the buffer.
- wr_data  in  8  operand pair: [3:0] = a, [7:4] = b.
- full  out  1  buffer holds DEPTH entries.
- count  out  CNT_W  number of buffered entries.
- start  in  1  single-cycle request to run the buffered vector.
- busy  out  1  run in progress; high in every state except IDLE.
- mac_a  out  4  MAC operand a; registered.
- mac_b  out  4  MAC operand b; registered.
- mac_clr  out  1  accumulator clear, driven to the MAC reset; registered and glitch-free.
- mac_acc  in  8  MAC accumulator value C.
- result  out  8  captured dot product; held until the next capture.
- result_valid  out  1  one-cycle pulse when `result` updates.

## Operation
- Reset values: mac_a = 0, mac_b = 0, mac_clr = 0, result = 0, result_valid = 0, busy = 0, count = 0, full = 0. State is IDLE.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - mac_a and mac_b are held at 0, so the MAC adds 0 and the accumulator holds.
  - `wr_en` with `full` = 0 pushes one entry.
  - `wr_en` with `full` = 1 is dropped.
  - `start` with count > 0 latches N = count and moves to CLEAR.
  - `start` with count = 0 is ignored.
  - If `start` and `wr_en` occur in the same cycle, the write lands first and is included in N.
- CLEAR: one cycle. mac_clr = 1 and operands = 0. Moves to STREAM.
- STREAM: N cycles. In cycle k, mac_a and mac_b carry entry k in write order. Moves to DRAIN after entry N-1.
- DRAIN: one cycle. Operands = 0. mac_acc is sampled into `result`. Moves to DONE.
- DONE: one cycle. result_valid = 1. The buffer is emptied (count = 0). Moves to IDLE.
- While `busy` is high, `wr_en` and `start` are ignored; the buffer is locked.
- Arithmetic: `result` is the 8-bit sum of a×b over all entries, modulo 256. Each product is at most 225; wrap-around is not flagged.
- `rst` mid-run: all outputs and state return to reset values immediately and the buffer is emptied. No `result_valid` is produced for the aborted run.

## Timing
- `start` is sampled at edge E0.
- CLEAR occupies the cycle after E0.
- STREAM occupies cycles 2 .. N+1.
- DRAIN occupies cycle N+2.
- result_valid is high in cycle N+3. Total latency from `start` to `result_valid` is N+3 cycles.
- mac_acc is valid during DRAIN: the MAC registers each product one edge after the operands are presented.
- Back-to-back: a new run may be started from the first IDLE cycle after DONE.

## Structure
- Shared package mac_pkg holds:
  - the FSM state enum (feeder_state_t);
  - OPW = 4 and ACCW = 8;
  - helper constants for packing the {b,a} pair.
- One sub-module, mac_operand_fifo:
  - DEPTH×8 storage;
  - write pointer and read pointer;
  - count, full, and a pop interface.
  - The feeder FSM owns the pop and the empty-on-DONE.

## Test plan
- Basic run: write {b=2,a=3}, {b=4,a=5}, {b=1,a=1}, then `start` → one cycle of mac_clr, operand sequence (3,2), (5,4), (1,1), result = 27 with result_valid exactly 6 cycles after `start`, count = 0 afterwards.
- Full buffer and wrap: write DEPTH = 8 entries of {b=15,a=15}, plus a 9th write → full = 1, 9th write dropped, result = 8×225 mod 256 = 8.
- Empty start: `start` with count = 0 → busy stays 0, no mac_clr, no result_valid.
- Locked buffer: during STREAM, assert wr_en with data and a second `start` → both ignored; result is unchanged from the expected value; count = 0 after DONE.
- Reset mid-STREAM: assert `rst` in cycle 3 of a 5-entry run → all outputs are 0 immediately, no result_valid follows, and a fresh 1-entry run {b=6,a=7} afterwards gives result = 42.
- Simultaneous write and start: with 1 entry buffered, `wr_en`+`start` in the same cycle → N = 2 and both products accumulate.
